dev_bus_arbiter: RTL and testbench
==================================

Name: dev_bus_arbiter

Overview:
- Sequences and shares the system device bus between two masters: M0 (CPU, via the bridge) and M1 (DMA/debug port).
- Decodes the word address into a one-hot device select and runs each access as a handshake with the devices.
- Returns read data and a completion pulse to the granted master.
- Write-data lane alignment stays with the bridge; this block passes data and byte enables through unmodified.

Parameters:
- DEV_BASE, 26'h00001FC, addr[31:6] match value for the device window (0x00007F00–0x00007F3F).
- TIMEOUT, 16, max BUSY cycles before the watchdog forces completion (used only with TIMEOUT_EN).

Ports:
- clk_I  in  1  system clock, rising edge.
- rst_n_I  in  1  asynchronous active-low reset.
- M0_Req_I, M1_Req_I  in  1 each  access request; held until the matching Ack.
- M0_We_I, M1_We_I  in  1 each  1=write, 0=read.
- M0_Addr_I, M1_Addr_I  in  30 each  word address [31:2].
- M0_BE_I, M1_BE_I  in  4 each  byte enables.
- M0_WD_I, M1_WD_I  in  32 each  write data, already lane-aligned.
- M0_Gnt_O, M1_Gnt_O  out  1 each  high from grant through the Ack cycle.
- M0_Ack_O, M1_Ack_O  out  1 each  one-cycle completion pulse.
- Err_O  out  1  qualifies Ack: decode error or timeout.
- RD_O  out  32  read data, valid in the Ack cycle.
- DEV_Sel_O  out  4  one-hot device select from addr[5:4].
- DEV_Addr_O  out  2  addr[3:2], register index inside the device.
- DEV_We_O  out  1  write strobe.
- DEV_BE_O  out  4  byte enables.
- DEV_WD_O  out  32  write data.
- DEV_RD_I  in  32  selected device read data.
- DEV_Ready_I  in  1  device completes the access this cycle.

Behaviour:
- Reset (async, rst_n_I=0):
  - state=IDLE, rr_last=M1, so M0 has priority first.
  - All outputs 0; latched request registers 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any Req is high, grant one. If both are high, grant the master other than rr_last. Update rr_last to the granted master.
  - Latch the granted master's We/Addr/BE/WD. Assert its Gnt from the next cycle.
  - If latched addr[31:6]==DEV_BASE, go to BUSY. Otherwise go to DONE with err flag set.
- BUSY:
  - Drive DEV_Sel_O = 1<<addr[5:4], DEV_Addr_O, DEV_BE_O, DEV_WD_O, and DEV_We_O = latched We.
  - These stay stable every BUSY cycle. A device commits writes only in the cycle where DEV_Ready_I=1.
  - When DEV_Ready_I=1, capture DEV_RD_I (reads only; writes capture 0), go to DONE, err=0.
- DONE:
  - DEV_Sel_O=0, DEV_We_O=0.
  - Granted Ack=1 for exactly one cycle, with Err_O and RD_O valid. Err decode: RD_O=0.
  - Next state IDLE; Gnt drops at that edge.
- Latency:
  - Zero-wait device: Req seen at edge k, BUSY during k..k+1, Ack during cycle k+2. Req-to-Ack is 2 cycles.
  - Each wait cycle adds 1. A decode error takes 1 cycle.
- Back-to-back:
  - IDLE always lasts at least 1 cycle between accesses.
  - A master dropping Req in the cycle after Ack is mandatory. Req still high in IDLE is treated as a new request.
- Req dropped before Ack: protocol violation. The access still completes and Ack is still issued.
- Other master's Req while busy: ignored until IDLE; no starvation, because round-robin alternates when both are pending.
- DEV_Ready_I outside BUSY: ignored.
- Reset mid-access: immediate return to IDLE with outputs 0. No Ack is issued for the aborted access.

Optional Feature:
- Macro: DEV_BUS_TIMEOUT_EN.
- Defined:
  - A 5-bit counter clears on entering BUSY and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT-1 with DEV_Ready_I still 0, go to DONE with Err_O=1 and RD_O=0.
  - If ready and timeout coincide, ready wins (err=0).
- Undefined: no counter; BUSY waits indefinitely for DEV_Ready_I.

Test Plan:
- M0 read, Addr=0x7F10>>2, DEV_Ready_I=1 immediately, DEV_RD_I=0xDEADBEEF -> DEV_Sel_O=4'b0010, DEV_Addr_O=0; M0_Ack_O pulses 2 cycles after Req; RD_O=0xDEADBEEF; Err_O=0.
- M1 write to 0x7F24, BE=4'b0011, WD=0x00001234, ready after 3 wait cycles -> DEV_Sel_O=4'b0100, DEV_We_O held 4 cycles, Ack in cycle 5, RD_O=0.
- M0 and M1 both Req continuously from reset, zero-wait device -> grants alternate M0, M1, M0, M1; each Ack period is 3 cycles.
- M0 read at 0x00001000 -> no DEV_Sel_O activity; Ack 1 cycle after Req with Err_O=1, RD_O=0.
- rst_n_I pulsed low in the 2nd BUSY cycle of a waiting write -> all outputs 0 asynchronously; no Ack. After release, the same held Req is re-granted to M0.
- DEV_BUS_TIMEOUT_EN, TIMEOUT=16, DEV_Ready_I stuck 0 -> Ack with Err_O=1 after 16 BUSY cycles. Same run with ready rising in the 16th BUSY cycle -> Err_O=0.

Source files
------------

// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the device bus window.
// Optional watchdog on stalled devices: define DEV_BUS_TIMEOUT_EN.
module dev_bus_arbiter #(
    parameter logic [25:0] DEV_BASE = 26'h00001FC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_I,
    input  logic        rst_n_I,
    input  logic        M0_Req_I,
    input  logic        M1_Req_I,
    input  logic        M0_We_I,
    input  logic        M1_We_I,
    input  logic [29:0] M0_Addr_I,
    input  logic [29:0] M1_Addr_I,
    input  logic [3:0]  M0_BE_I,
    input  logic [3:0]  M1_BE_I,
    input  logic [31:0] M0_WD_I,
    input  logic [31:0] M1_WD_I,
    output logic        M0_Gnt_O,
    output logic        M1_Gnt_O,
    output logic        M0_Ack_O,
    output logic        M1_Ack_O,
    output logic        Err_O,
    output logic [31:0] RD_O,
    output logic [3:0]  DEV_Sel_O,
    output logic [1:0]  DEV_Addr_O,
    output logic        DEV_We_O,
    output logic [3:0]  DEV_BE_O,
    output logic [31:0] DEV_WD_O,
    input  logic [31:0] DEV_RD_I,
    input  logic        DEV_Ready_I
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_rr_last, r_owner, r_we, r_err;
    logic [1:0]  r_dev_idx, r_reg_idx;
    logic [3:0]  r_be;
    logic [31:0] r_wd, r_rd;

    logic        w_any, w_pick, w_hit, w_ready, w_tmo;
    logic [29:0] w_addr;

    assign w_any   = M0_Req_I | M1_Req_I;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    assign w_pick  = (M0_Req_I & M1_Req_I) ? ~r_rr_last : M1_Req_I;
    assign w_addr  = w_pick ? M1_Addr_I : M0_Addr_I;
    assign w_hit   = (w_addr[29:4] == DEV_BASE);
    assign w_ready = (r_state == S_BUSY) && DEV_Ready_I;

`ifdef DEV_BUS_TIMEOUT_EN
    logic [4:0] r_tcnt;

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I)                r_tcnt <= '0;
        else if (r_state != S_BUSY)  r_tcnt <= '0;
        else if (!DEV_Ready_I)       r_tcnt <= r_tcnt + 5'd1;
    end

    // Ready in the final allowed cycle wins over the watchdog.
    assign w_tmo = (r_state == S_BUSY) && !DEV_Ready_I && (r_tcnt == 5'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_hit ? S_BUSY : S_DONE;
            S_BUSY:  if (w_ready || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) begin
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_dev_idx <= '0;
            r_reg_idx <= '0;
            r_be      <= '0;
            r_wd      <= '0;
            r_rd      <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_rr_last <= w_pick;
            r_owner   <= w_pick;
            r_we      <= w_pick ? M1_We_I : M0_We_I;
            r_err     <= ~w_hit;
            r_dev_idx <= w_addr[3:2];
            r_reg_idx <= w_addr[1:0];
            r_be      <= w_pick ? M1_BE_I : M0_BE_I;
            r_wd      <= w_pick ? M1_WD_I : M0_WD_I;
            r_rd      <= '0;
        end else if (w_ready) begin
            r_err     <= 1'b0;
            r_rd      <= r_we ? 32'h0 : DEV_RD_I;
        end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_rd      <= '0;
        end
    end

    always_comb begin
        M0_Gnt_O   = 1'b0;
        M1_Gnt_O   = 1'b0;
        M0_Ack_O   = 1'b0;
        M1_Ack_O   = 1'b0;
        Err_O      = 1'b0;
        RD_O       = '0;
        DEV_Sel_O  = '0;
        DEV_Addr_O = '0;
        DEV_We_O   = 1'b0;
        DEV_BE_O   = '0;
        DEV_WD_O   = '0;
        if (r_state != S_IDLE) begin
            M0_Gnt_O = ~r_owner;
            M1_Gnt_O = r_owner;
        end
        if (r_state == S_BUSY) begin
            DEV_Sel_O  = 4'b0001 << r_dev_idx;
            DEV_Addr_O = r_reg_idx;
            DEV_We_O   = r_we;
            DEV_BE_O   = r_be;
            DEV_WD_O   = r_wd;
        end
        if (r_state == S_DONE) begin
            M0_Ack_O = ~r_owner;
            M1_Ack_O = r_owner;
            Err_O    = r_err;
            RD_O     = r_rd;
        end
    end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Scoreboard bench for dev_bus_arbiter: directed accesses queue expected Acks,
// a negedge monitor pops and compares them; a behavioural device answers the bus.
module tb_dev_bus_arbiter;

    logic        clk_I = 1'b0;
    logic        rst_n_I;
    logic        M0_Req_I, M1_Req_I, M0_We_I, M1_We_I;
    logic [29:0] M0_Addr_I, M1_Addr_I;
    logic [3:0]  M0_BE_I, M1_BE_I;
    logic [31:0] M0_WD_I, M1_WD_I;
    logic        M0_Gnt_O, M1_Gnt_O, M0_Ack_O, M1_Ack_O, Err_O;
    logic [31:0] RD_O;
    logic [3:0]  DEV_Sel_O;
    logic [1:0]  DEV_Addr_O;
    logic        DEV_We_O;
    logic [3:0]  DEV_BE_O;
    logic [31:0] DEV_WD_O;
    logic [31:0] DEV_RD_I;
    logic        DEV_Ready_I;

    dev_bus_arbiter dut (
        .clk_I(clk_I), .rst_n_I(rst_n_I),
        .M0_Req_I(M0_Req_I), .M1_Req_I(M1_Req_I),
        .M0_We_I(M0_We_I), .M1_We_I(M1_We_I),
        .M0_Addr_I(M0_Addr_I), .M1_Addr_I(M1_Addr_I),
        .M0_BE_I(M0_BE_I), .M1_BE_I(M1_BE_I),
        .M0_WD_I(M0_WD_I), .M1_WD_I(M1_WD_I),
        .M0_Gnt_O(M0_Gnt_O), .M1_Gnt_O(M1_Gnt_O),
        .M0_Ack_O(M0_Ack_O), .M1_Ack_O(M1_Ack_O),
        .Err_O(Err_O), .RD_O(RD_O),
        .DEV_Sel_O(DEV_Sel_O), .DEV_Addr_O(DEV_Addr_O), .DEV_We_O(DEV_We_O),
        .DEV_BE_O(DEV_BE_O), .DEV_WD_O(DEV_WD_O),
        .DEV_RD_I(DEV_RD_I), .DEV_Ready_I(DEV_Ready_I)
    );

    always #5 clk_I = ~clk_I;

    int cyc = 0;
    always @(posedge clk_I) cyc <= cyc + 1;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] rd;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural device: answers after dev_waits stall cycles; asserts stray
    // ready outside an access, which the arbiter must ignore.
    int          dev_waits = 0;
    logic [31:0] dev_rdata = 32'h0;
    int          bcnt = 0;
    int          we_cnt = 0;
    bit          sel_seen = 0;
    logic [3:0]  last_sel = '0;
    logic [1:0]  last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wd = '0;
    logic        last_we = 1'b0;

    always @(negedge clk_I) begin
        if (DEV_Sel_O != 4'b0) begin
            sel_seen = 1;
            if (DEV_We_O) we_cnt++;
            DEV_Ready_I = (bcnt >= dev_waits);
            bcnt++;
            DEV_RD_I = DEV_Ready_I ? dev_rdata : 32'hBAD0_BAD0;
            if (DEV_Ready_I) begin
                last_sel  = DEV_Sel_O;
                last_addr = DEV_Addr_O;
                last_be   = DEV_BE_O;
                last_wd   = DEV_WD_O;
                last_we   = DEV_We_O;
            end
        end else begin
            bcnt        = 0;
            DEV_Ready_I = 1'b1;
            DEV_RD_I    = 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk_I) begin
        exp_t e;
        if (rst_n_I && (M0_Ack_O || M1_Ack_O)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got M0=%0b M1=%0b required no Ack (cycle %0d)",
                         M0_Ack_O, M1_Ack_O, cyc);
            end else begin
                e = q.pop_front();
                chk("ack_master", {M1_Ack_O, M0_Ack_O}, e.m ? 2'b10 : 2'b01);
                chk("ack_err",    Err_O, e.err);
                chk("ack_rd",     RD_O, e.rd);
                chk("ack_cycle",  cyc, e.cyc);
                chk("ack_gnt",    {M1_Gnt_O, M0_Gnt_O}, e.m ? 2'b10 : 2'b01);
                chk("ack_sel_off", {DEV_Sel_O, DEV_We_O}, 5'b0);
            end
        end
    end

    function automatic logic [95:0] all_outs();
        return {16'h0, M0_Gnt_O, M1_Gnt_O, M0_Ack_O, M1_Ack_O, Err_O, RD_O,
                DEV_Sel_O, DEV_Addr_O, DEV_We_O, DEV_BE_O, DEV_WD_O};
    endfunction

    task automatic issue(input bit m, input bit we, input logic [29:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input bit err, input logic [31:0] rd,
                         input int lat, input bit push);
        @(posedge clk_I);
        #1;
        if (!m) begin
            M0_We_I = we; M0_Addr_I = a; M0_BE_I = be; M0_WD_I = wd; M0_Req_I = 1'b1;
        end else begin
            M1_We_I = we; M1_Addr_I = a; M1_BE_I = be; M1_WD_I = wd; M1_Req_I = 1'b1;
        end
        if (push) q.push_back('{m, err, rd, cyc + lat});
    endtask

    task automatic finish_access(input bit m);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk_I);
            seen = m ? M1_Ack_O : M0_Ack_O;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: master %0d got no Ack required within 300 cycles", m);
        end
        @(posedge clk_I);
        #1;
        if (!m) M0_Req_I = 1'b0;
        else    M1_Req_I = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) begin
            @(negedge clk_I);
            #1;
        end
        chk("scoreboard_drained", q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk_I);
        #2 rst_n_I = 1'b0;
        #10 rst_n_I = 1'b1;
    endtask

    initial begin
        rst_n_I = 1'b0;
        M0_Req_I = 0; M1_Req_I = 0; M0_We_I = 0; M1_We_I = 0;
        M0_Addr_I = '0; M1_Addr_I = '0; M0_BE_I = '0; M1_BE_I = '0;
        M0_WD_I = '0; M1_WD_I = '0;
        DEV_RD_I = '0; DEV_Ready_I = 1'b0;

        #22;
        chk("reset_outputs", all_outs(), 96'h0);
        rst_n_I = 1'b1;
        repeat (2) @(posedge clk_I);
        chk("idle_outputs", all_outs(), 96'h0);

        // M0 zero-wait read of 0x7F10
        dev_waits = 0; dev_rdata = 32'hDEADBEEF;
        issue(0, 0, 30'h1FC4, 4'hF, 32'h0, 0, 32'hDEADBEEF, 2, 1);
        finish_access(0);
        chk("t1_sel_addr_we", {last_sel, last_addr, last_we}, {4'b0010, 2'd0, 1'b0});

        // M1 write to 0x7F24 with three stall cycles
        dev_waits = 3; we_cnt = 0;
        issue(1, 1, 30'h1FC9, 4'b0011, 32'h00001234, 0, 32'h0, 5, 1);
        finish_access(1);
        chk("t2_sel_addr", {last_sel, last_addr}, {4'b0100, 2'd1});
        chk("t2_be_wd", {last_be, last_wd}, {4'b0011, 32'h00001234});
        chk("t2_we_cycles", we_cnt, 4);

        // Decode error outside the device window
        sel_seen = 0; dev_waits = 0;
        issue(0, 0, 30'h400, 4'hF, 32'h0, 1, 32'h0, 1, 1);
        finish_access(0);
        chk("t3_no_dev_sel", sel_seen, 0);

        // Both masters requesting continuously from reset: alternation every 3 cycles
        drain();
        pulse_reset();
        dev_waits = 0; dev_rdata = 32'h0BAD_CAFE;
        @(posedge clk_I);
        #1;
        M0_We_I = 0; M0_Addr_I = 30'h1FC0; M0_BE_I = 4'hF; M0_WD_I = 32'h0;
        M1_We_I = 1; M1_Addr_I = 30'h1FCF; M1_BE_I = 4'hC; M1_WD_I = 32'h5555_0000;
        M0_Req_I = 1; M1_Req_I = 1;
        q.push_back('{0, 0, 32'h0BAD_CAFE, cyc + 2});
        q.push_back('{1, 0, 32'h0,         cyc + 5});
        q.push_back('{0, 0, 32'h0BAD_CAFE, cyc + 8});
        q.push_back('{1, 0, 32'h0,         cyc + 11});
        drain();
        @(posedge clk_I);
        #1;
        M0_Req_I = 0; M1_Req_I = 0;

        // Reset in the 2nd BUSY cycle of a stalled write; held Req is re-granted
        repeat (2) @(posedge clk_I);
        dev_waits = 5;
        issue(0, 1, 30'h1FCC, 4'hF, 32'hA5A5_0001, 0, 32'h0, 0, 0);
        @(posedge clk_I);
        @(posedge clk_I);
        chk("t5_busy_before_reset", {DEV_Sel_O, DEV_We_O}, {4'b1000, 1'b1});
        #2 rst_n_I = 1'b0;
        #1;
        chk("t5_async_reset_outputs", all_outs(), 96'h0);
        #4 rst_n_I = 1'b1;
        q.push_back('{0, 0, 32'h0, cyc + 7});
        finish_access(0);

`ifdef DEV_BUS_TIMEOUT_EN
        // Device stuck: watchdog completes after 16 BUSY cycles
        dev_waits = 1000;
        issue(0, 0, 30'h1FC4, 4'hF, 32'h0, 1, 32'h0, 17, 1);
        finish_access(0);
        // Ready in the 16th BUSY cycle beats the watchdog
        dev_waits = 15; dev_rdata = 32'h5A5A_5A5A;
        issue(0, 0, 30'h1FC4, 4'hF, 32'h0, 0, 32'h5A5A_5A5A, 17, 1);
        finish_access(0);
`endif

        drain();
        repeat (3) @(posedge clk_I);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
